piso_serializer: RTL

Parametrised parallel-in/serial-out serializer. It is the successor to the team's fixed 8-bit PISO shift register.
- Adds a valid/ready load handshake and a one-entry holding buffer, so frames stream back-to-back with no gap bits.
- Bit order and idle line level are selectable.
- Adds an external bit-rate enable, frame-start/done strobes and a synchronous abort.
- Sits between a parallel word source (FIFO, register file) and a serial line driver.

---
 rtl/piso_pkg.sv | 29 ++
 rtl/piso_serializer_if.sv | 37 +++
 rtl/piso_hold_buf.sv | 56 +++++
 rtl/piso_serializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out serializer slice.
//
// Contents:
//   ORDER_MSB_FIRST / ORDER_LSB_FIRST  bit-order selector values for MSB_FIRST
//   bitcnt_w(width)                     width of a counter holding 0..width
//   emit_e                              what the shifter does on a given edge
// ---------------------------------------------------------------------------
package piso_pkg;

  localparam int ORDER_MSB_FIRST = 1;
  localparam int ORDER_LSB_FIRST = 0;

  // Enough bits to count from 0 up to and including width.
  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Per-edge shifter action. EMIT_HOLD covers edges without shift_en, where
  // the line and the shifter keep their values.
  typedef enum logic [1:0] {
    EMIT_HOLD  = 2'd0,
    EMIT_SHIFT = 2'd1,
    EMIT_LOAD  = 2'd2,
    EMIT_IDLE  = 2'd3
  } emit_e;

endpackage

// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Valid/ready load interface between a parallel word source and the
// serializer.
//
// Signals:
//   in_valid  source -> serializer  in_data holds a word
//   in_ready  serializer -> source  holding buffer can take a word
//   in_data   source -> serializer  parallel word, WIDTH bits
//
// Modports:
//   master  word source side
//   slave   serializer side
// ---------------------------------------------------------------------------
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/piso_hold_buf.sv
// ---------------------------------------------------------------------------
// piso_hold_buf
// One-entry valid/ready holding register in front of the shifter. A word is
// captured whenever the entry is empty and in_valid is high; the shifter
// empties it with drain when it starts a new frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   clear      synchronous flush (same effect as reset)
//   in_valid   in_data holds a word
//   in_ready   entry is empty (registered, no path from in_valid)
//   in_data    parallel word
//   drain      shifter takes the stored word this edge
//   hold_full  entry holds a word
//   hold_data  stored word
// ---------------------------------------------------------------------------
module piso_hold_buf
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             drain,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  logic accept;

  // Accept needs an empty entry and drain needs a full one, so the two can
  // never happen on the same edge and need no priority between them.
  assign accept   = in_valid && !hold_full;
  assign in_ready = !hold_full;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (drain) begin
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parametrised parallel-in/serial-out serializer. Words arrive over a
// valid/ready interface into a one-entry holding buffer, so the next frame
// can be queued while the current one shifts out and frames run back-to-back
// without idle bits. One bit leaves per clock edge with shift_en high.
//
// Parameters:
//   WIDTH       bits per frame, 1..64
//   MSB_FIRST   ORDER_MSB_FIRST emits bit WIDTH-1 first, ORDER_LSB_FIRST bit 0
//   IDLE_LEVEL  line level when no frame bit is being emitted
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   abort        synchronous flush of the current frame and the held word
//   shift_en     bit-rate enable
//   in_if        load interface (slave modport): in_valid/in_ready/in_data
//   serial_out   registered serial data
//   frame_start  1-cycle strobe with the first bit of a frame
//   done         1-cycle strobe with the last bit of a frame
//   busy         a frame is in progress or a word is held
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = ORDER_MSB_FIRST,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               abort,
  input  logic               shift_en,
  piso_serializer_if.slave   in_if,
  output logic               serial_out,
  output logic               frame_start,
  output logic               done,
  output logic               busy
);

  localparam int CNT_W = bitcnt_w(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bits_left;

  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] bits_left_d;
  logic             serial_d;
  logic             frame_start_d;
  logic             done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             drain;
  emit_e            action;

  // Bit that leaves the word first under the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != ORDER_LSB_FIRST) begin
      return v[WIDTH-1];
    end
    return v[0];
  endfunction

  // Move the next bit into the emitting end, zero-filling behind it. For
  // WIDTH=1 this always yields zero, which is harmless as bits_left is 0.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != ORDER_LSB_FIRST) begin
      return v << 1;
    end
    return v >> 1;
  endfunction

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort),
    .in_valid  (in_if.in_valid),
    .in_ready  (in_if.in_ready),
    .in_data   (in_if.in_data),
    .drain     (drain),
    .hold_full (hold_full),
    .hold_data (hold_data)
  );

  // A frame still shifting always wins over the held word; the held word is
  // loaded on the very edge the shifter runs dry, which is what removes the
  // gap between frames. The loaded word's first bit goes straight to the
  // line, so the shifter only keeps the remaining WIDTH-1 bits.
  always_comb begin
    action        = EMIT_HOLD;
    shreg_d       = shreg;
    bits_left_d   = bits_left;
    serial_d      = serial_out;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    drain         = 1'b0;

    if (shift_en) begin
      if (bits_left != '0) begin
        action = EMIT_SHIFT;
      end else if (hold_full) begin
        action = EMIT_LOAD;
      end else begin
        action = EMIT_IDLE;
      end
    end

    case (action)
      EMIT_SHIFT: begin
        serial_d    = first_bit(shreg);
        shreg_d     = shift_one(shreg);
        bits_left_d = bits_left - CNT_W'(1);
        done_d      = (bits_left == CNT_W'(1));
      end
      EMIT_LOAD: begin
        serial_d      = first_bit(hold_data);
        shreg_d       = shift_one(hold_data);
        bits_left_d   = CNT_W'(WIDTH - 1);
        frame_start_d = 1'b1;
        done_d        = (WIDTH == 1);
        drain         = 1'b1;
      end
      EMIT_IDLE: begin
        serial_d = IDLE_LEVEL;
      end
      default: begin
      end
    endcase
  end

  // Abort is a soft reset of the datapath; the holding buffer is flushed by
  // the same signal through its clear input.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      shreg       <= '0;
      bits_left   <= '0;
      serial_out  <= IDLE_LEVEL;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      shreg       <= shreg_d;
      bits_left   <= bits_left_d;
      serial_out  <= serial_d;
      frame_start <= frame_start_d;
      done        <= done_d;
    end
  end

  assign busy = (bits_left != '0) || hold_full;

endmodule
